result_tx: RTL and testbench

Framed result transmitter for the hash-search core. On a one-cycle `send_i` request it captures a search result (best Hamming distance plus the winning nonce). It then emits a checksummed byte frame on the serial TX user interface (`tx_data`/`new_tx_data`/`tx_busy`) toward the AVR. It sits inside `chip_top`, between the search engine and the `avr_interface` TX port, and is the outbound counterpart of the command receiver that consumes `rx_new`/`rx_data`.

---
 rtl/result_tx.sv | 116 +++++++++++
 tb/tb_result_tx.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_tx.sv
// result_tx: captures a search result on send_i and transmits it as an 0xA5-headed,
// XOR-checksummed byte frame over the serial TX strobe/busy handshake.
module result_tx #(
    parameter int unsigned NONCE_BYTES = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     send_i,
    input  logic [15:0]              distance_i,
    input  logic [8*NONCE_BYTES-1:0] nonce_i,
    input  logic                     tx_busy_i,
    output logic                     tx_new_o,
    output logic [7:0]               tx_data_o,
    output logic                     busy_o,
    output logic                     done_o
);
    localparam int unsigned FRAME_LEN = NONCE_BYTES + 4;
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
    localparam int unsigned PAY_W     = 8 * (FRAME_LEN - 1);
    localparam logic [7:0]  HEADER    = 8'hA5;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t           state_q, state_d;
    logic [PAY_W-1:0] payload_q, payload_d;
    logic [7:0]       csum_q, csum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tx_new_d, busy_d, done_d;
    logic [7:0]       tx_data_d;
    logic             last_c, accept_c;
    logic [7:0]       cur_byte_c;

    // Payload is a shift register: header, distance and nonce leave MSB-first, checksum last.
    assign last_c     = (idx_q == IDX_W'(FRAME_LEN - 1));
    assign cur_byte_c = last_c ? csum_q : payload_q[PAY_W-1 -: 8];
    // busy_o lags the state by one cycle; a request is honoured only once busy_o reads low.
    assign accept_c   = send_i && !busy_o;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_c) state_d = S_WAIT;
            S_WAIT:  if (!tx_busy_i) state_d = S_HOLD;
            S_HOLD:  state_d = last_c ? S_IDLE : S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        tx_new_d  = 1'b0;
        tx_data_d = tx_data_o;
        done_d    = 1'b0;
        busy_d    = (state_q != S_IDLE);
        payload_d = payload_q;
        csum_d    = csum_q;
        idx_d     = idx_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    payload_d = {HEADER, distance_i, nonce_i};
                    csum_d    = 8'h00;
                    idx_d     = '0;
                end
            end
            S_WAIT: begin
                if (!tx_busy_i) begin
                    tx_new_d  = 1'b1;
                    tx_data_d = cur_byte_c;
                    csum_d    = csum_q ^ cur_byte_c;
                    payload_d = {payload_q[PAY_W-9:0], 8'h00};
                end
            end
            S_HOLD: begin
                // tx_busy_i is ignored here: the transmitter raises it one cycle after a strobe.
                if (last_c) begin
                    done_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_new_o  <= 1'b0;
            tx_data_o <= 8'h00;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            payload_q <= '0;
            csum_q    <= 8'h00;
            idx_q     <= '0;
        end else begin
            tx_new_o  <= tx_new_d;
            tx_data_o <= tx_data_d;
            busy_o    <= busy_d;
            done_o    <= done_d;
            payload_q <= payload_d;
            csum_q    <= csum_d;
            idx_q     <= idx_d;
        end
    end
endmodule

// File: tb/tb_result_tx.sv
// Testbench for result_tx: two instances (2-byte and 8-byte nonce) checked against a
// frame model built directly from the header/distance/nonce/XOR rules.
module tb_result_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        send2, send8, txb2, txb8;
    logic [15:0] dist2, dist8, nonce2;
    logic [63:0] nonce8;
    logic        new2, new8, busy2, busy8, done2, done8;
    logic [7:0]  data2, data8;

    result_tx #(.NONCE_BYTES(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .send_i(send2), .distance_i(dist2), .nonce_i(nonce2),
        .tx_busy_i(txb2), .tx_new_o(new2), .tx_data_o(data2), .busy_o(busy2), .done_o(done2));
    result_tx #(.NONCE_BYTES(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .send_i(send8), .distance_i(dist8), .nonce_i(nonce8),
        .tx_busy_i(txb8), .tx_new_o(new8), .tx_data_o(data8), .busy_o(busy8), .done_o(done8));

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_cyc[$];
    logic       busy_tr[$];
    int done_cnt, done_cyc, consec_err, busy_err, late_strobe;
    bit timeout;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference frame: header, distance MSB first, nonce MSB first, XOR of everything before.
    function automatic void model_frame(input logic [15:0] d, input logic [63:0] n, input int nb);
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
        for (int i = nb - 1; i >= 0; i--) exp_q.push_back(n[8*i +: 8]);
        x = 8'h00;
        foreach (exp_q[i]) x ^= exp_q[i];
        exp_q.push_back(x);
    endfunction

    // One-cycle request; the edge that samples it is cycle 0.
    task automatic start(input bit wide, input logic [15:0] d, input logic [63:0] n);
        if (wide) begin
            send8 = 1'b1; dist8 = d; nonce8 = n;
        end else begin
            send2 = 1'b1; dist2 = d; nonce2 = n[15:0];
        end
        tick();
        send8 = 1'b0;
        send2 = 1'b0;
    endtask

    // Records strobes/done/busy; models a serial port busy for busy_len cycles after each strobe.
    task automatic collect(input bit wide, input int budget, input int busy_len, input bit spam);
        int cyc = 0;
        int cnt = 0;
        int stop_at = budget;
        bit applied;
        bit prev_new = 1'b0;
        bit done_seen = 1'b0;
        bit s_new, s_done, s_busy;
        logic [7:0] s_data;
        got_q.delete(); got_cyc.delete(); busy_tr.delete();
        done_cnt = 0; done_cyc = -1; consec_err = 0; busy_err = 0; late_strobe = 0;
        while (cyc < stop_at) begin
            applied = wide ? txb8 : txb2;
            tick();
            cyc++;
            s_new  = wide ? new8 : new2;
            s_done = wide ? done8 : done2;
            s_busy = wide ? busy8 : busy2;
            s_data = wide ? data8 : data2;
            busy_tr.push_back(s_busy);
            if (s_new) begin
                if (prev_new) consec_err++;
                if (applied) busy_err++;
                if (done_seen) late_strobe++;
                got_q.push_back(s_data);
                got_cyc.push_back(cyc);
            end
            prev_new = s_new;
            if (s_done) begin
                done_cnt++;
                if (!done_seen) begin
                    done_seen = 1'b1;
                    done_cyc = cyc;
                    stop_at = cyc + 8;
                end
            end
            if (busy_len > 0) begin
                if (s_new) cnt = busy_len;
                txb2 = (cnt > 0);
                txb8 = (cnt > 0);
                if (cnt > 0) cnt--;
            end
            if (spam) begin
                if (!done_seen || s_busy) begin
                    send2 = 1'b1; dist2 = 16'($urandom); nonce2 = 16'($urandom);
                end else begin
                    send2 = 1'b0;
                end
            end
        end
        timeout = !done_seen;
        txb2 = 1'b0; txb8 = 1'b0; send2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({new2, data2, busy2, done2} !== 11'h0) begin
            failures++;
            $display("FAIL reset dut2: got %h expected %h", {new2, data2, busy2, done2}, 11'h0);
        end
        checks++;
        if ({new8, data8, busy8, done8} !== 11'h0) begin
            failures++;
            $display("FAIL reset dut8: got %h expected %h", {new8, data8, busy8, done8}, 11'h0);
        end
    endtask

    task automatic test_basic();
        model_frame(16'h0123, 64'hBEEF, 2);
        start(1'b0, 16'h0123, 64'hBEEF);
        collect(1'b0, 60, 0, 1'b0);
        checks++;
        if (timeout) begin failures++; $display("FAIL basic done timeout: got none expected 1"); end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL basic length: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL basic byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
            checks++;
            if (i >= got_cyc.size() || got_cyc[i] != 1 + 2 * i) begin
                failures++; $display("FAIL basic strobe_cycle[%0d]: got %0d expected %0d", i, got_cyc[i], 1 + 2 * i);
            end
        end
        checks++;
        if (done_cyc != 12) begin failures++; $display("FAIL basic done_cycle: got %0d expected 12", done_cyc); end
        checks++;
        if ({busy_tr[0], busy_tr[11], busy_tr[12]} !== 3'b110) begin
            failures++; $display("FAIL basic busy@1,12,13: got %b expected 110", {busy_tr[0], busy_tr[11], busy_tr[12]});
        end
        checks++;
        if (consec_err != 0) begin failures++; $display("FAIL basic back_to_back_strobes: got %0d expected 0", consec_err); end
    endtask

    task automatic test_stall();
        logic [15:0] d;
        logic [15:0] n;
        for (int r = 0; r < 2; r++) begin
            d = 16'($urandom); n = 16'($urandom);
            model_frame(d, 64'(n), 2);
            start(1'b0, d, 64'(n));
            collect(1'b0, 600, (r == 0) ? 10 : int'($urandom_range(1, 6)), 1'b0);
            checks++;
            if (timeout || done_cnt != 1) begin
                failures++; $display("FAIL stall%0d done_count: got %0d expected 1", r, done_cnt);
            end
            checks++;
            if (got_q.size() != exp_q.size()) begin
                failures++; $display("FAIL stall%0d length: got %0d expected %0d", r, got_q.size(), exp_q.size());
            end
            foreach (exp_q[i]) begin
                checks++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL stall%0d byte[%0d]: got %h expected %h", r, i, got_q[i], exp_q[i]);
                end
            end
            checks++;
            if (busy_err != 0 || consec_err != 0) begin
                failures++; $display("FAIL stall%0d strobe_while_busy/back_to_back: got %0d/%0d expected 0/0", r, busy_err, consec_err);
            end
        end
    endtask

    task automatic test_spam();
        model_frame(16'h0123, 64'hBEEF, 2);
        start(1'b0, 16'h0123, 64'hBEEF);
        collect(1'b0, 60, 0, 1'b1);
        checks++;
        if (timeout || done_cnt != 1) begin failures++; $display("FAIL spam done_count: got %0d expected 1", done_cnt); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL spam byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (late_strobe != 0 || busy2 !== 1'b0) begin
            failures++; $display("FAIL spam second_frame: got strobes=%0d busy=%b expected 0/0", late_strobe, busy2);
        end
    endtask

    task automatic test_done_send();
        int k = 0;
        model_frame(16'h0123, 64'hBEEF, 2);
        start(1'b0, 16'h0123, 64'hBEEF);
        while (done2 !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        checks++;
        if (k >= 60) begin failures++; $display("FAIL done_send wait_done: got timeout expected done"); end
        send2 = 1'b1; dist2 = 16'hFFFF; nonce2 = 16'h1234;
        tick();
        send2 = 1'b0;
        checks++;
        if ({busy2, new2} !== 2'b00) begin
            failures++; $display("FAIL done_send busy/new after done: got %b expected 00", {busy2, new2});
        end
        model_frame(16'h0000, 64'h0, 2);
        start(1'b0, 16'h0000, 64'h0);
        collect(1'b0, 60, 0, 1'b0);
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL done_send byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (got_cyc.size() == 0 || got_cyc[0] != 1) begin
            failures++; $display("FAIL done_send first_strobe_cycle: got %0d expected 1", got_cyc[0]);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int k = 0;
        int s = 0;
        int dn = 0;
        logic [15:0] d;
        logic [15:0] n;
        start(1'b0, 16'($urandom), 64'($urandom));
        while (seen < 3 && k < 60) begin
            tick();
            k++;
            if (new2 === 1'b1) seen++;
        end
        checks++;
        if (seen != 3) begin failures++; $display("FAIL reset_mid strobes_before_reset: got %0d expected 3", seen); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({new2, data2, busy2, done2} !== 11'h0) begin
            failures++; $display("FAIL reset_mid outputs: got %h expected %h", {new2, data2, busy2, done2}, 11'h0);
        end
        repeat (30) begin
            tick();
            if (new2 === 1'b1) s++;
            if (done2 === 1'b1) dn++;
        end
        checks++;
        if (s != 0 || dn != 0) begin
            failures++; $display("FAIL reset_mid activity_after_reset: got strobes=%0d done=%0d expected 0/0", s, dn);
        end
        d = 16'($urandom); n = 16'($urandom);
        model_frame(d, 64'(n), 2);
        start(1'b0, d, 64'(n));
        collect(1'b0, 60, 0, 1'b0);
        checks++;
        if (timeout || done_cnt != 1) begin failures++; $display("FAIL reset_mid fresh_done: got %0d expected 1", done_cnt); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL reset_mid fresh_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_wide();
        logic [15:0] d;
        logic [63:0] n;
        model_frame(16'hFFFF, 64'h0102030405060708, 8);
        start(1'b1, 16'hFFFF, 64'h0102030405060708);
        collect(1'b1, 100, 0, 1'b0);
        checks++;
        if (got_q.size() != 12) begin failures++; $display("FAIL wide length: got %0d expected 12", got_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL wide byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (got_q.size() != 12 || got_q[11] !== 8'hAD) begin
            failures++; $display("FAIL wide checksum: got %h expected ad", got_q[11]);
        end
        checks++;
        if (done_cyc != 24) begin failures++; $display("FAIL wide done_cycle: got %0d expected 24", done_cyc); end
        d = 16'($urandom); n = {$urandom, $urandom};
        model_frame(d, n, 8);
        start(1'b1, d, n);
        collect(1'b1, 800, int'($urandom_range(1, 4)), 1'b0);
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL wide_rand byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (timeout || busy_err != 0) begin
            failures++; $display("FAIL wide_rand strobe_while_busy: got %0d (timeout=%0d) expected 0", busy_err, timeout);
        end
    endtask

    initial begin
        rst = 1'b1;
        send2 = 1'b0; send8 = 1'b0; txb2 = 1'b0; txb8 = 1'b0;
        dist2 = 16'h0; dist8 = 16'h0; nonce2 = 16'h0; nonce8 = 64'h0;
        test_reset();
        test_basic();
        test_stall();
        test_spam();
        test_done_send();
        test_reset_mid();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
